// File: rtl/denise_bpl_serializer.sv
// Bitplane serializer: eight BPLxDAT holding registers, parallel-load shifters,
// lores/hires/superhires shift rates and per-parity scroll delay lines.
module denise_bpl_serializer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pix_en,
    input  logic        hires,
    input  logic        shres,
    input  logic        wr_en,
    input  logic [2:0]  wr_plane,
    input  logic [15:0] data_in,
    input  logic [3:0]  scroll_odd,
    input  logic [3:0]  scroll_even,
    output logic [7:0]  bpldata,
    output logic        load_strobe
);

    logic [15:0] hold_q  [8];
    logic [15:0] shift_q [8];
    logic [59:0] hist_q  [8];
    logic [7:0]  bpldata_q;
    logic [7:0]  bpldata_d;
    logic        load_pend_q;
    logic [1:0]  phase_q;
    logic        load_evt;
    logic        shift_step;
    logic [3:0]  sc;
    logic [60:0] tap_vec;

    assign load_evt = pix_en && (phase_q == 2'd3) && load_pend_q;

    // shres overrides hires; lores steps once per four slots
    assign shift_step = shres || (hires && phase_q[0]) || (phase_q == 2'd3);

    // Bit 0 of tap_vec is the live MSB, bit 4*s is the MSB from s lores pixels ago.
    always_comb begin
        bpldata_d = '0;
        sc        = '0;
        tap_vec   = '0;
        for (int p = 0; p < 8; p++) begin
            sc           = (p % 2 == 0) ? scroll_odd : scroll_even;
            tap_vec      = {hist_q[p], shift_q[p][15]};
            bpldata_d[p] = tap_vec[{sc, 2'b00}];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int p = 0; p < 8; p++) begin
                hold_q[p]  <= '0;
                shift_q[p] <= '0;
                hist_q[p]  <= '0;
            end
            bpldata_q   <= '0;
            load_pend_q <= 1'b0;
            phase_q     <= '0;
        end else begin
            if (wr_en) begin
                hold_q[wr_plane] <= data_in;
            end
            // a BPL1DAT write colliding with a load keeps the load armed
            if (wr_en && (wr_plane == 3'd0)) begin
                load_pend_q <= 1'b1;
            end else if (load_evt) begin
                load_pend_q <= 1'b0;
            end
            if (pix_en) begin
                phase_q   <= phase_q + 2'd1;
                bpldata_q <= bpldata_d;
                for (int p = 0; p < 8; p++) begin
                    hist_q[p] <= {hist_q[p][58:0], shift_q[p][15]};
                    if (load_evt) begin
                        shift_q[p] <= hold_q[p];
                    end else if (shift_step) begin
                        shift_q[p] <= {shift_q[p][14:0], 1'b0};
                    end
                end
            end
        end
    end

    assign bpldata     = bpldata_q;
    assign load_strobe = load_evt && reset_n;

endmodule

// File: tb/tb_denise_bpl_serializer.sv
// Self-checking bench for denise_bpl_serializer against a slot-level pixel-stream model.
module tb_denise_bpl_serializer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pix_en;
    logic        hires;
    logic        shres;
    logic        wr_en;
    logic [2:0]  wr_plane;
    logic [15:0] data_in;
    logic [3:0]  scroll_odd;
    logic [3:0]  scroll_even;
    logic [7:0]  bpldata;
    logic        load_strobe;

    always #5 clk = ~clk;

    denise_bpl_serializer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pix_en     (pix_en),
        .hires      (hires),
        .shres      (shres),
        .wr_en      (wr_en),
        .wr_plane   (wr_plane),
        .data_in    (data_in),
        .scroll_odd (scroll_odd),
        .scroll_even(scroll_even),
        .bpldata    (bpldata),
        .load_strobe(load_strobe)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Model: per plane, the queue of MSB values each future slot will sample,
    // plus the list of past samples (newest first) for the scroll delay.
    bit [15:0] m_hold [8];
    bit        m_pend;
    int        m_slots;
    bit        m_q    [8][$];
    bit        m_hist [8][$];
    bit [7:0]  m_bpl;
    logic [7:0] last_bpl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit pix, input bit wr, input bit [2:0] pl,
                                input bit [15:0] d, input bit evt);
        int s;
        int rate;
        bit smp;
        if (!reset_n) begin
            for (int p = 0; p < 8; p++) begin
                m_hold[p] = '0;
                m_q[p].delete();
                m_hist[p].delete();
            end
            m_pend  = 0;
            m_slots = 0;
            m_bpl   = '0;
            return;
        end
        if (pix) begin
            rate = shres ? 1 : (hires ? 2 : 4);
            for (int p = 0; p < 8; p++) begin
                smp = (m_q[p].size() > 0) ? m_q[p].pop_front() : 1'b0;
                m_hist[p].push_front(smp);
                if (m_hist[p].size() > 64) void'(m_hist[p].pop_back());
                s = (p % 2 == 0) ? int'(scroll_odd) : int'(scroll_even);
                m_bpl[p] = (m_hist[p].size() > 4 * s) ? m_hist[p][4 * s] : 1'b0;
                if (evt) begin
                    m_q[p].delete();
                    for (int b = 15; b >= 0; b--)
                        for (int k = 0; k < rate; k++) m_q[p].push_back(m_hold[p][b]);
                end
            end
            m_slots++;
        end
        if (wr) m_hold[pl] = d;
        if (wr && pl == 3'd0) m_pend = 1;
        else if (evt) m_pend = 0;
    endtask

    task automatic step(input bit pix, input bit wr, input bit [2:0] pl, input bit [15:0] d);
        bit evt;
        pix_en   = pix;
        wr_en    = wr;
        wr_plane = pl;
        data_in  = d;
        evt = reset_n && pix && (m_slots % 4 == 3) && m_pend;
        @(negedge clk);
        chk("load_strobe", {31'd0, load_strobe}, {31'd0, evt});
        chk("bpldata", {24'd0, bpldata}, {24'd0, m_bpl});
        last_bpl = bpldata;
        @(posedge clk);
        #1;
        model_update(pix, wr, pl, d, evt);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(1, 0, 0, 0);
        reset_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0);
    endtask

    initial begin
        int cnt;
        int r1;
        int r2;
        reset_n = 1'b0; pix_en = 0; hires = 0; shres = 0; wr_en = 0;
        wr_plane = 0; data_in = 0; scroll_odd = 0; scroll_even = 0;
        m_pend = 0; m_slots = 0; m_bpl = '0; last_bpl = '0;
        @(posedge clk);
        #1;
        do_reset();
        step(1, 0, 0, 0);
        chk("reset_bpl", {24'd0, last_bpl}, 32'd0);

        // lores 0x8001: 4 slots high, 56 low, 4 high
        do_reset();
        step(1, 1, 0, 16'h8001);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            step(1, 0, 0, 0);
            if (last_bpl[0]) cnt++;
        end
        chk("lores_high_slots", cnt, 8);

        // hires then shres 0xAAAA
        do_reset();
        hires = 1;
        step(1, 1, 0, 16'hAAAA);
        idle(40);
        do_reset();
        shres = 1;
        step(1, 1, 0, 16'hAAAA);
        idle(24);
        hires = 0; shres = 0;

        // odd scroll 3 delays plane 1 by 12 slots relative to plane 2
        do_reset();
        scroll_odd = 4'd3;
        step(1, 1, 1, 16'h8000);
        step(1, 1, 0, 16'h8000);
        r1 = -1; r2 = -1;
        for (int i = 0; i < 90; i++) begin
            step(1, 0, 0, 0);
            if (last_bpl[0] && r1 < 0) r1 = i;
            if (last_bpl[1] && r2 < 0) r2 = i;
        end
        chk("scroll_gap", r1 - r2, 12);
        scroll_odd = 0;

        // load arming: BPL3DAT alone, then BPL1DAT at phase 1
        do_reset();
        step(1, 1, 2, 16'hFFFF);
        idle(8);
        do_reset();
        step(1, 0, 0, 0);
        step(1, 1, 0, 16'hC3C3);
        idle(20);

        // collision: BPL1DAT written on the load slot
        do_reset();
        step(1, 1, 0, 16'hFFFF);
        idle(2);
        step(1, 1, 0, 16'h0001);
        idle(80);

        // reset in the middle of an active line
        do_reset();
        step(1, 1, 0, 16'hF0F0);
        step(1, 1, 3, 16'hFFFF);
        idle(20);
        do_reset();
        idle(100);

        // randomized segments: mode fixed per segment, gappy pix_en, random writes
        for (int seg = 0; seg < 4; seg++) begin
            do_reset();
            hires = seg[0];
            shres = (seg == 3);
            scroll_odd  = 4'($urandom_range(0, 15));
            scroll_even = 4'($urandom_range(0, 15));
            for (int i = 0; i < 400; i++) begin
                if ($urandom_range(0, 49) == 0) scroll_odd  = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 49) == 0) scroll_even = 4'($urandom_range(0, 15));
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                     3'($urandom_range(0, 7)), 16'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
